// File: rtl/inv_loop_checker.sv
// inv_loop_checker: LFSR stimulus driver that checks an inverted response RespLatency cycles later; define INV_LOOP_CHECKER_FIRST_ERR_EN to capture the first mismatch index.
module inv_loop_checker #(
  parameter int unsigned SeqLen      = 16,
  parameter int unsigned RespLatency = 0,
  parameter int unsigned ErrCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [15:0]            seed_i,
  output logic                   signal_one_o,
  input  logic                   signal_two_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [15:0]            first_err_o
);
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] LAST_I = 16'(SeqLen - 1);
  localparam logic [3:0] LAST_D = 4'(RespLatency - 1);
`ifdef INV_LOOP_CHECKER_FIRST_ERR_EN
  localparam int DW = 17;
`else
  localparam int DW = 1;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [15:0] lfsr, idx;
  logic [3:0] dcnt;
  logic go, run, fin, err, d_vld;
  logic [DW-1:0] cur_dat, d_dat;
  assign go = state == IDLE && start_i;
  assign run = state == RUN;
  assign signal_one_o = run & lfsr[0];
`ifdef INV_LOOP_CHECKER_FIRST_ERR_EN
  assign cur_dat = {idx, lfsr[0]};
`else
  assign cur_dat = lfsr[0];
`endif
  assign fin = (run && idx == LAST_I && RespLatency == 0) || (state == DRAIN && dcnt == LAST_D);
  assign err = d_vld && state != IDLE && signal_two_i == d_dat[0];
  generate
    if (RespLatency == 0) begin : g_direct
      assign d_vld = run;
      assign d_dat = cur_dat;
    end else begin : g_delay
      logic [RespLatency-1:0] vld;
      logic [DW-1:0] dat [RespLatency];
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) vld <= '0;
        else if (go) vld <= '0;
        else begin
          vld[0] <= run;
          for (int i = 1; i < RespLatency; i++) vld[i] <= vld[i-1];
        end
      always_ff @(posedge clk_i) begin
        dat[0] <= cur_dat;
        for (int i = 1; i < RespLatency; i++) dat[i] <= dat[i-1];
      end
      assign d_vld = vld[RespLatency-1];
      assign d_dat = dat[RespLatency-1];
    end
  endgenerate
  // pass looks ahead at the final comparison, which lands on the same edge as DONE entry
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      lfsr <= SEED_DEF;
      idx <= '0;
      dcnt <= '0;
      err_cnt_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
    end else begin
      done_o <= fin;
      if (err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
      if (fin) pass_o <= err_cnt_o == '0 && !err;
      case (state)
        IDLE: if (start_i) begin
          state <= RUN;
          busy_o <= 1'b1;
          lfsr <= seed_i == '0 ? SEED_DEF : seed_i;
          idx <= '0;
          dcnt <= '0;
          err_cnt_o <= '0;
          pass_o <= 1'b0;
        end
        RUN: begin
          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
          idx <= idx + 1'b1;
          if (idx == LAST_I) state <= RespLatency == 0 ? DONE : DRAIN;
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (fin) state <= DONE;
        end
        default: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
`ifdef INV_LOOP_CHECKER_FIRST_ERR_EN
  logic [15:0] first_err;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) first_err <= '1;
    else if (go) first_err <= '1;
    else if (err && err_cnt_o == '0) first_err <= d_dat[DW-1:1];
  assign first_err_o = first_err;
`else
  assign first_err_o = 16'hFFFF;
`endif
endmodule

// File: tb/tb_inv_loop_checker.sv
// tb_inv_loop_checker: scoreboard bench for a zero-latency and a three-stage-latency checker instance.
module tb_inv_loop_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] seed = '0;
  int mode = 0;
  int errors = 0, checks = 0;
  logic [1:0] s1, busy, done, pass;
  logic ra, rb, p1, p2, p3;
  logic [7:0] ec_a;
  logic [3:0] ec_b;
  logic [15:0] fe_a, fe_b;
  always #5 clk = ~clk;
  inv_loop_checker u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seed_i(seed), .signal_one_o(s1[0]),
    .signal_two_i(ra), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
    .err_cnt_o(ec_a), .first_err_o(fe_a));
  inv_loop_checker #(.SeqLen(20), .RespLatency(3), .ErrCntWidth(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seed_i(seed), .signal_one_o(s1[1]),
    .signal_two_i(rb), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
    .err_cnt_o(ec_b), .first_err_o(fe_b));
  // responder: 0 inverts, 1 stuck at 0, 2 passes the bit through
  assign ra = mode == 0 ? ~s1[0] : mode == 1 ? 1'b0 : s1[0];
  always @(posedge clk) begin
    p1 <= mode == 0 ? ~s1[1] : mode == 1 ? 1'b0 : s1[1];
    p2 <= p1;
    p3 <= p2;
  end
  assign rb = p3;
  typedef struct {
    logic [19:0] stim;
    logic [7:0] err;
    logic pass;
    logic [15:0] first;
    int lat;
  } exp_t;
  exp_t q0[$], q1[$];
  task automatic chk(string tag, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, want %0h", tag, n, act, exp);
    end
  endtask
  function automatic exp_t model(logic [15:0] s, int len, int lat, int md, int w);
    exp_t e;
    logic [15:0] r;
    int cnt, sat;
    logic b, mis;
    r = s == 16'h0 ? 16'hACE1 : s;
    cnt = 0;
    e.stim = '0;
    e.first = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      b = r[0];
      e.stim[i] = b;
      mis = md == 2 ? 1'b1 : md == 1 ? !b : 1'b0;
      if (mis && cnt == 0) e.first = 16'(i);
      if (mis) cnt++;
      r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
    end
    sat = (1 << w) - 1;
    e.err = 8'(cnt > sat ? sat : cnt);
    e.pass = cnt == 0;
`ifndef INV_LOOP_CHECKER_FIRST_ERR_EN
    e.first = 16'hFFFF;
`endif
    e.lat = len + lat + 1;
    return e;
  endfunction
  initial begin
    int cyc [2];
    logic [19:0] cap [2];
    int len_n [2];
    exp_t e;
    len_n[0] = 16;
    len_n[1] = 20;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!rst_n || !busy[n]) cyc[n] = 0;
        else begin
          cyc[n] = cyc[n] + 1;
          if (cyc[n] == 1) cap[n] = '0;
          if (cyc[n] <= len_n[n]) cap[n][cyc[n]-1] = s1[n];
        end
        if (rst_n && done[n]) begin
          if ((n == 0 ? q0.size() : q1.size()) == 0) chk("spurious_done", n, 1, 0);
          else begin
            if (n == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk("done_lat", n, cyc[n], e.lat);
            chk("stim", n, cap[n], e.stim);
            chk("err_cnt", n, n == 0 ? ec_a : {4'b0, ec_b}, e.err);
            chk("pass", n, pass[n], e.pass);
            chk("first_err", n, n == 0 ? fe_a : fe_b, e.first);
          end
        end
      end
    end
  end
  task automatic check_idle();
    for (int n = 0; n < 2; n++) begin
      chk("rst_sig", n, s1[n], 0);
      chk("rst_busy", n, busy[n], 0);
      chk("rst_done", n, done[n], 0);
      chk("rst_pass", n, pass[n], 0);
      chk("rst_err", n, n == 0 ? ec_a : {4'b0, ec_b}, 0);
      chk("rst_first", n, n == 0 ? fe_a : fe_b, 16'hFFFF);
    end
  endtask
  task automatic wait_done();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("timeout", 0, 1, 0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic launch(logic [15:0] s, int md, int copies);
    @(negedge clk);
    seed = s;
    mode = md;
    start = 1'b1;
    for (int i = 0; i < copies; i++) begin
      q0.push_back(model(s, 16, 0, md, 8));
      q1.push_back(model(s, 20, 3, md, 4));
    end
  endtask
  task automatic run(logic [15:0] s, int md, bit poke);
    launch(s, md, 1);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_idle();
    rst_n = 1'b1;
    run(16'h0001, 0, 0);
    run(16'h0001, 1, 0);
    run(16'h5A5A, 2, 0);
    run(16'h0000, 0, 1);
    launch(16'h1234, 1, 2);
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_done();
    launch(16'h0001, 0, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run(16'h0001, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inv_loop_checker.md
INV_LOOP_CHECKER -- requirements
Module: inv_loop_checker

Purpose: stimulus-generating counterpart for an inverting responder. Drives a pseudo-random bit stream on signal_one_o, checks that signal_two_i returns its inverse after a fixed latency, and reports errors.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock is clk_i and the reset is rst_ni.
REQ-002 Parameter SeqLen: int unsigned, default 16, number of stimulus bits per run, legal range 1..65535.
REQ-003 Parameter RespLatency: int unsigned, default 0, cycles from a bit on signal_one_o to its inverse on signal_two_i, legal range 0..15.
REQ-004 Parameter ErrCntWidth: int unsigned, default 8, width of the error counter.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  start request, sampled only in IDLE.
REQ-008 seed_i  in  16  LFSR seed, captured together with start_i.
REQ-009 signal_one_o  out  1  stimulus bit.
REQ-010 signal_two_i  in  1  response from the device under check.
REQ-011 busy_o  out  1  high in RUN, DRAIN and DONE.
REQ-012 done_o  out  1  one-cycle pulse at the end of a run.
REQ-013 pass_o  out  1  result of the last completed run; held until the next start.
REQ-014 err_cnt_o  out  ErrCntWidth  number of mismatches in the current or last run.
REQ-015 first_err_o  out  16  index of the first mismatching bit (see Configuration).

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE with start_i=1, the block SHALL load the LFSR with seed_i, or with 16'hACE1 if seed_i==0.
REQ-018 On that same start, the block SHALL clear err_cnt_o to 0, clear the bit index to 0, set first_err_o to 16'hFFFF, and go to RUN.
REQ-019 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1, shifting right once per RUN cycle.
REQ-020 During RUN, signal_one_o SHALL equal lfsr[0]; in all other states signal_one_o SHALL be 0.
REQ-021 RUN SHALL last exactly SeqLen cycles.
REQ-022 After RUN, the FSM SHALL go to DRAIN if RespLatency>0 and stay there RespLatency cycles; otherwise it SHALL go directly to DONE.
REQ-023 Each driven bit and its index SHALL pass through a RespLatency-deep valid/data delay line; with RespLatency=0 the path is direct.
REQ-024 In every cycle where a delayed valid bit b is present, the block SHALL compare signal_two_i against ~b.
REQ-025 Each mismatch SHALL increment err_cnt_o, saturating at 2^ErrCntWidth-1 with no wrap.
REQ-026 DONE SHALL last one cycle with done_o=1; pass_o SHALL be registered as (err_cnt==0) in that cycle.
REQ-027 After DONE, the FSM SHALL return to IDLE.
REQ-028 done_o SHALL be asserted exactly 1+SeqLen+RespLatency cycles after the clock edge that sampled start_i.
REQ-029 start_i asserted in RUN, DRAIN or DONE SHALL be ignored, with no queuing.
REQ-030 start_i held high SHALL restart a run on the first IDLE cycle after DONE.
REQ-031 The delay line SHALL be flushed (all valids 0) on each start.
REQ-032 No comparison SHALL occur in IDLE.

Reset
REQ-033 Reset SHALL take effect asynchronously and be released synchronously to clk_i.
REQ-034 During reset, the FSM SHALL go to IDLE and the LFSR SHALL be set to 16'hACE1.
REQ-035 During reset, the delay-line valids SHALL be 0, and the outputs SHALL be: signal_one_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, first_err_o=16'hFFFF.
REQ-036 Reset asserted mid-run SHALL abort the run with no done_o pulse.

Configuration
REQ-037 Macro INV_LOOP_CHECKER_FIRST_ERR_EN defined: first_err_o SHALL capture the index of the first mismatch in a run and hold it until the next start.
REQ-038 With INV_LOOP_CHECKER_FIRST_ERR_EN defined, later mismatches SHALL NOT overwrite first_err_o, and first_err_o SHALL stay 16'hFFFF if no mismatch occurs.
REQ-039 Macro INV_LOOP_CHECKER_FIRST_ERR_EN undefined: first_err_o SHALL be constant 16'hFFFF and no capture register SHALL be built; all other behaviour is identical.

Verification
REQ-040 Ideal inverter loopback, SeqLen=16, RespLatency=0, seed=16'h0001, start pulsed at edge k -> done_o=1 in cycle k+17, pass_o=1, err_cnt_o=0, first_err_o=16'hFFFF.
REQ-041 Loopback through a 3-stage register inverter, RespLatency=3, SeqLen=16 -> busy_o high for 20 cycles, done_o at k+20, pass_o=1.
REQ-042 Response stuck at 0, SeqLen=16, seed=16'h0001 -> err_cnt_o equals the number of 0 bits in the 16-bit stimulus stream, pass_o=0; with FIRST_ERR_EN, first_err_o equals the index of the first 0 bit.
REQ-043 Non-inverting loopback, SeqLen=300, ErrCntWidth=8 -> err_cnt_o=255 (saturated), pass_o=0.
REQ-044 seed_i=0 -> first 16 stimulus bits match the sequence from seed 16'hACE1; start_i pulsed mid-RUN -> no effect on the bit count or on done_o timing.
REQ-045 rst_ni asserted in cycle 5 of RUN -> all outputs return to reset values immediately and no done_o pulse occurs; a new start after release behaves as in REQ-040.
